// File: rtl/gol_step_ctrl.sv
// gol_step_ctrl
// Computes one Game of Life generation (B3/S23, dead borders) over a byte-per-cell
// grid held in on-chip memory, or zero-fills the result region on request.
//
// Ports
//   clk_clk, reset_reset_n          : clock, asynchronous active-low reset
//   start_i, initialize_i           : command PIO levels; a rising edge launches a command
//   soft_reset_i                    : abort to IDLE while high
//   start_address_i, result_address_i : source / result base (low ADDR_W bits used)
//   rows_i, columns_i               : grid geometry, sampled when a command is accepted
//   completed_o                     : high in DONE
//   mem_*                           : s2 port of the on-chip memory
//
// Handshake: the s2 port has no backpressure. A read is issued by chipselect=1,
// write=0 and its data is taken exactly RD_LAT cycles later. A write is a single
// cycle with chipselect=1, write=1.
//
// ADDR_W must be below 16 (the upper base-address bits are discarded).
module gol_step_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start_i,
  input  logic              initialize_i,
  input  logic              soft_reset_i,
  input  logic [15:0]       start_address_i,
  input  logic [15:0]       result_address_i,
  input  logic [7:0]        rows_i,
  input  logic [7:0]        columns_i,
  output logic              completed_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_chipselect_o,
  output logic              mem_clken_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  input  logic [DATA_W-1:0] mem_readdata_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // command edge detection
  logic start_prev_q, init_prev_q;
  logic start_edge, init_edge, can_accept, accept_init, accept_start, accept_any;

  // geometry latched at command acceptance
  logic [ADDR_W-1:0] src_q, res_q;
  logic [7:0]        rows_q, cols_q;
  logic              empty_q;

  // scan position: row/column, linear offset r*C+c, neighbour slot (sr,sc)
  logic [7:0]  row_q, col_q;
  logic [15:0] lin_q;
  logic [1:0]  sr_q, sc_q;
  logic [1:0]  drain_q;

  // read-return pipeline: one entry per issued slot
  logic [RD_LAT-1:0] pv_q, pg_q, pc_q;

  logic [3:0] nb_cnt_q;
  logic       alive_q;

  logic              last_slot, last_cell, row_ok, col_ok, in_grid, issue, next_val;
  logic [ADDR_W-1:0] cols_a, row_off, col_off, nb_addr, res_addr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{start_address_i[15:ADDR_W], result_address_i[15:ADDR_W]};

  assign start_edge   = start_i & ~start_prev_q;
  assign init_edge    = initialize_i & ~init_prev_q;
  assign can_accept   = (state_q == S_IDLE) || (state_q == S_DONE);
  // initialize wins over a simultaneous start
  assign accept_init  = can_accept & init_edge & ~soft_reset_i;
  assign accept_start = can_accept & start_edge & ~init_edge & ~soft_reset_i;
  assign accept_any   = accept_init | accept_start;

  assign last_slot = (sr_q == 2'd2) && (sc_q == 2'd2);
  assign last_cell = (row_q == rows_q - 8'd1) && (col_q == cols_q - 8'd1);

  // slot (sr,sc) maps to (dr,dc) = (sr-1, sc-1)
  always_comb begin
    row_ok = 1'b1;
    col_ok = 1'b1;
    if (sr_q == 2'd0) row_ok = (row_q != 8'd0);
    if (sr_q == 2'd2) row_ok = (row_q != rows_q - 8'd1);
    if (sc_q == 2'd0) col_ok = (col_q != 8'd0);
    if (sc_q == 2'd2) col_ok = (col_q != cols_q - 8'd1);
  end
  assign in_grid = row_ok & col_ok;

  // neighbour address = src + r*C + c + dr*C + dc, all modulo 2^ADDR_W
  assign cols_a  = ADDR_W'(cols_q);
  assign row_off = (sr_q == 2'd0) ? -cols_a : (sr_q == 2'd2) ? cols_a : '0;
  assign col_off = (sc_q == 2'd0) ? '1 : (sc_q == 2'd2) ? ADDR_W'(1) : '0;
  assign nb_addr  = src_q + ADDR_W'(lin_q) + row_off + col_off;
  assign res_addr = res_q + ADDR_W'(lin_q);

  // out-of-grid slots still enter the pipeline so spacing is uniform
  assign issue    = (state_q == S_READ) && !empty_q;
  assign next_val = (nb_cnt_q == 4'd3) | (alive_q & (nb_cnt_q == 4'd2));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    completed_o      = 1'b0;
    mem_address_o    = '0;
    mem_chipselect_o = 1'b0;
    mem_clken_o      = 1'b0;
    mem_write_o      = 1'b0;
    mem_writedata_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept_init)       state_d = S_CLEAR;
        else if (accept_start) state_d = S_READ;
      end
      S_DONE: begin
        mem_clken_o = 1'b1;
        completed_o = 1'b1;
        if (accept_init)       state_d = S_CLEAR;
        else if (accept_start) state_d = S_READ;
      end
      S_READ: begin
        mem_clken_o = 1'b1;
        if (empty_q) begin
          state_d = S_DONE;
        end else begin
          mem_chipselect_o = in_grid;
          mem_address_o    = nb_addr;
          if (last_slot) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        mem_clken_o = 1'b1;
        if (drain_q == 2'(RD_LAT - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_clken_o      = 1'b1;
        mem_chipselect_o = 1'b1;
        mem_write_o      = 1'b1;
        mem_address_o    = res_addr;
        mem_writedata_o  = {{(DATA_W-1){1'b0}}, next_val};
        state_d          = last_cell ? S_DONE : S_READ;
      end
      S_CLEAR: begin
        mem_clken_o = 1'b1;
        if (empty_q) begin
          state_d = S_DONE;
        end else begin
          mem_chipselect_o = 1'b1;
          mem_write_o      = 1'b1;
          mem_address_o    = res_addr;
          if (last_cell) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (soft_reset_i) begin
      state_d     = S_IDLE;
      completed_o = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      start_prev_q <= 1'b0;
      init_prev_q  <= 1'b0;
      src_q        <= '0;
      res_q        <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      empty_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      lin_q        <= '0;
      sr_q         <= '0;
      sc_q         <= '0;
      drain_q      <= '0;
      pv_q         <= '0;
      pg_q         <= '0;
      pc_q         <= '0;
      nb_cnt_q     <= '0;
      alive_q      <= 1'b0;
    end else begin
      start_prev_q <= start_i;
      init_prev_q  <= initialize_i;

      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pg_q[i] <= pg_q[i-1];
        pc_q[i] <= pc_q[i-1];
      end
      pv_q[0] <= issue;
      pg_q[0] <= in_grid;
      pc_q[0] <= (sr_q == 2'd1) && (sc_q == 2'd1);
      if (soft_reset_i) pv_q <= '0;

      // returning data is valid exactly RD_LAT cycles after its slot
      if (pv_q[RD_LAT-1]) begin
        if (pc_q[RD_LAT-1])
          alive_q <= (mem_readdata_i != '0);
        else if (pg_q[RD_LAT-1] && (mem_readdata_i != '0))
          nb_cnt_q <= nb_cnt_q + 4'd1;
      end

      if (accept_any) begin
        src_q    <= start_address_i[ADDR_W-1:0];
        res_q    <= result_address_i[ADDR_W-1:0];
        rows_q   <= rows_i;
        cols_q   <= columns_i;
        empty_q  <= (rows_i == 8'd0) || (columns_i == 8'd0);
        row_q    <= '0;
        col_q    <= '0;
        lin_q    <= '0;
        sr_q     <= '0;
        sc_q     <= '0;
        drain_q  <= '0;
        nb_cnt_q <= '0;
        alive_q  <= 1'b0;
      end else begin
        case (state_q)
          S_READ: begin
            if (!empty_q) begin
              if (last_slot) begin
                sr_q    <= '0;
                sc_q    <= '0;
                drain_q <= '0;
              end else if (sc_q == 2'd2) begin
                sc_q <= '0;
                sr_q <= sr_q + 2'd1;
              end else begin
                sc_q <= sc_q + 2'd1;
              end
            end
          end
          S_DRAIN: drain_q <= drain_q + 2'd1;
          S_WRITE, S_CLEAR: begin
            if (!empty_q) begin
              if (col_q == cols_q - 8'd1) begin
                col_q <= '0;
                row_q <= row_q + 8'd1;
              end else begin
                col_q <= col_q + 8'd1;
              end
              lin_q <= lin_q + 16'd1;
            end
            if (state_q == S_WRITE) begin
              nb_cnt_q <= '0;
              alive_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/gol_step_ctrl.md
# gol_step_ctrl

Fabric-side sequencer that computes one Game of Life generation over the HPS-shared on-chip memory. The HPS writes a grid of one byte per cell (0 = dead, nonzero = alive) and programs the address, size and command PIOs. This block then drives the on-chip memory s2 port to read the grid at `start_address`, apply B3/S23 with dead (non-wrapping) edges, and write the next grid at `result_address`. It reports through the `completed` PIO input and also services the `initialize` command (zero-fill of the result region).

## Interface

- `ADDR_W`, 12: s2 address width; all address arithmetic is modulo 2^ADDR_W
- `DATA_W`, 8: s2 data width, one cell per word
- `RD_LAT`, 1: s2 read latency in cycles; legal values 1 and 2

- `clk_clk`  in  1  single clock, s2 port and PIO domain
- `reset_reset_n`  in  1  asynchronous, active-low reset
- `start_i`  in  1  start PIO level; rising edge launches a generation
- `initialize_i`  in  1  initialize PIO level; rising edge launches zero-fill of the result region
- `soft_reset_i`  in  1  reset PIO level; synchronous abort while high
- `start_address_i`  in  16  grid base; low ADDR_W bits used
- `result_address_i`  in  16  output base; low ADDR_W bits used
- `rows_i`  in  8  grid rows R
- `columns_i`  in  8  grid columns C
- `completed_o`  out  1  to completed PIO input
- `mem_address_o`  out  ADDR_W  s2 address
- `mem_chipselect_o`  out  1  s2 chipselect
- `mem_clken_o`  out  1  s2 clock enable
- `mem_write_o`  out  1  s2 write
- `mem_writedata_o`  out  DATA_W  s2 write data
- `mem_readdata_i`  in  DATA_W  s2 read data, valid RD_LAT cycles after a read issue

## Operation

- States: IDLE, READ (9 slots), DRAIN (RD_LAT cycles), WRITE, CLEAR, DONE.
- Commands:
  - Edge detection uses registered previous values of `start_i` and `initialize_i`.
  - Edges are accepted only in IDLE or DONE; edges in any other state are ignored.
  - If both edges occur in the same cycle, initialize wins.
- Geometry and addressing:
  - Row r and column c are scanned row-major from (0,0).
  - Cell address is base + r*C + c, truncated to ADDR_W bits, so it wraps past 0xFFF.
- READ: exactly 9 slots per cell, order (dr,dc) = (-1,-1),(-1,0),(-1,1),(0,-1),(0,0),(0,1),(1,-1),(1,0),(1,1).
  - In-grid slot: chipselect=1, write=0, address = source cell.
  - Out-of-grid slot: chipselect=0; the slot still consumes its cycle and counts as dead.
- Accumulate: a 4-bit neighbour count takes the 8 non-centre returns, each counted alive if nonzero. The centre return is stored separately as `alive`.
- WRITE: one cycle, chipselect=1, write=1, address = result base + r*C + c.
  - Write data is 8'h01 when (n==3) | (alive & n==2), else 8'h00.
  - After the write, advance to the next cell or go to DONE.
- CLEAR: one write of 8'h00 per cycle to result base + k, for k = 0..R*C-1, then DONE.
- R==0 or C==0: go straight to DONE with no memory access.
- DONE:
  - `completed_o` = 1, held until a new command is accepted or a soft reset.
  - Accepting a command clears it in the same cycle the state leaves DONE.
- `soft_reset_i` high: next state is IDLE and `completed_o` is 0. No chipselect is issued from the following cycle on, and partial results remain in memory.
- `mem_clken_o` is 1 in every state except IDLE.
- Overlapping source and result regions are not detected; the resulting data is unspecified.
- Geometry inputs are sampled at command acceptance and held internally; later changes take effect only on the next command.

## Timing

- Reset values: `completed_o`, `mem_chipselect_o`, `mem_write_o`, `mem_clken_o` are 0; `mem_address_o` and `mem_writedata_o` are 0; state is IDLE.
- Command edge seen in cycle T: the first s2 access (or the DONE entry for an empty grid) happens in cycle T+1.
- Generation: each cell takes 9 + RD_LAT + 1 cycles, so `completed_o` rises in cycle T+1+R*C*(10+RD_LAT).
- Initialize: `completed_o` rises in cycle T+1+R*C.
- Empty grid: `completed_o` rises in cycle T+2.
- Read data is captured strictly RD_LAT cycles after issue. Out-of-grid slots keep the same pipeline spacing as in-grid ones.
- Internal product r*C + c is at most 16 bits before truncation.

## Test plan

- 3x3 blinker:
  - Stimulus: source 0x000 = {0,0,0, 1,1,1, 0,0,0}, result 0x100, RD_LAT=1, start.
  - Required: result {0,1,0, 0,1,0, 0,1,0}; `completed_o` rises exactly 1+9*11 cycles after the edge cycle.
- 4x4 block still life:
  - Stimulus: centre 2x2 alive, all other cells dead.
  - Required: result identical to source. Corner cells show exactly 4 chipselect-high reads among their 9 slots.
- Empty grid and initialize:
  - Stimulus: R=0 with start.
  - Required: no chipselect; `completed_o`=1 at T+2.
  - Stimulus: then R=2, C=3, result 0x200, initialize.
  - Required: six writes of 0x00 to 0x200..0x205; `completed_o` at T+7.
- Address wrap:
  - Stimulus: start 0xFFE, result 0x7FE, 2x2 grid all alive.
  - Required: reads cover 0xFFE, 0xFFF, 0x000, 0x001; writes cover 0x7FE..0x801, all 0x01.
- Soft reset mid-run:
  - Stimulus: assert `soft_reset_i` for 1 cycle during cell 3 of the blinker.
  - Required: chipselect goes to 0 the next cycle; `completed_o` stays 0. A fresh start then produces a correct result.
- Retrigger and simultaneous commands:
  - Stimulus: toggle `start_i` while a generation is running.
  - Required: the toggle is ignored and timing is unchanged.
  - Stimulus: start and initialize edges in the same cycle.
  - Required: zero-fill only.
